subservient_dbg_mux: RTL and testbench
======================================

# subservient_dbg_mux

Wishbone debug arbiter between the Caravel management Wishbone slave port and the debug Wishbone interfaces of up to three `subservient` cores. It decodes the host address, forwards one transaction at a time to the selected core, and returns exactly one ack with that core's read data. It also hosts a small control/status register bank that holds each core in reset, drives each core's `i_debug_mode`, and records transaction timeouts. It sits in `user_project_wrapper` between `wbs_*` and the `i_wb_dbg_*`/`o_wb_dbg_*` ports of each `subservient` instance.

## Interface
- `N_CORES`, 3: number of attached cores, 1..3.
- `TIMEOUT`, 255: cycles a forwarded transaction may wait for a core ack, 1..255.
- `i_clk` input 1: clock (`wb_clk_i`).
- `i_rst` input 1: reset, asynchronous, active-high (`wb_rst_i`).
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i` input 1 each: host Wishbone classic request.
- `wbs_sel_i` input 4: byte enables.
- `wbs_adr_i`, `wbs_dat_i` input 32 each: host address, write data.
- `wbs_ack_o` output 1: host ack, one-cycle pulse.
- `wbs_dat_o` output 32: host read data, valid while `wbs_ack_o` is high, 0 otherwise.
- `o_dbg_adr` output 32: registered address to cores, with bits [31:20] zeroed.
- `o_dbg_dat` output 32, `o_dbg_sel` output 4, `o_dbg_we` output 1: registered, shared by all cores.
- `o_dbg_stb` output N_CORES: one-hot strobe per core.
- `i_dbg_rdt` input 32*N_CORES: core k read data in bits [32k+31:32k].
- `i_dbg_ack` input N_CORES: per-core ack.
- `o_core_rst` output N_CORES: per-core reset. OR it with `i_rst` in the wrapper.
- `o_debug_mode` output N_CORES: per-core `i_debug_mode`.

## Operation
- **Request.** A host request is valid when `wbs_cyc_i & wbs_stb_i`. It is accepted only in IDLE.
- **Decode.** `sel = wbs_adr_i[21:20]`.
  - `sel < N_CORES`: core k = sel.
  - `sel == 3`: register bank.
  - Any other value: null target. Ack with data 0; writes are dropped.
- **Register bank**, selected by `adr[3:2]`:
  - 0 = CTRL, read/write. Bits [N-1:0] are core reset holds, reset value all 1s. Bits [8+N-1:8] are debug_mode, reset value all 1s. Unused bits read 0.
  - 1 = STATUS. Bits [N-1:0] are sticky timeout flags, reset value 0, write-1-to-clear.
  - 2 and 3 read 0; writes to them are ignored.
  - Writes honour `wbs_sel_i` per byte.
- `o_core_rst` = CTRL[N-1:0]; `o_debug_mode` = CTRL[8+N-1:8]. Both are registered.
- **FSM states:** IDLE, FWD, RESP.
  - IDLE → FWD when a valid request targets a core. Latch adr/dat/sel/we, set `o_dbg_stb[k]`, load the timeout counter with TIMEOUT.
  - IDLE → RESP when a valid request targets the register bank or the null target. Perform the write or read and latch the response data.
  - FWD → RESP on `i_dbg_ack[k]`. Latch `i_dbg_rdt[k]` and clear `o_dbg_stb`.
  - FWD → RESP when the counter reaches 0 with no ack. Data = 32'hDEAD_BEEF, set STATUS[k], clear `o_dbg_stb`.
  - RESP → IDLE unconditionally; `wbs_ack_o` is high for exactly the RESP cycle.
- Acks from non-selected cores, and any ack outside FWD, are ignored.
- One transaction is outstanding at a time. No pipelining and no back-to-back acceptance: a request is re-evaluated only in IDLE.
- If a core ack and the timeout expire in the same cycle, the ack wins: core data is returned and no flag is set.
- Writing CTRL never aborts a transaction, because none can be in flight while the bank is accessed.

## Timing
- **Reset values:** `wbs_ack_o` 0, `wbs_dat_o` 0, `o_dbg_stb` 0, `o_dbg_adr`/`o_dbg_dat`/`o_dbg_sel`/`o_dbg_we` 0, `o_core_rst` all 1s, `o_debug_mode` all 1s, FSM in IDLE.
- Asserting `i_rst` mid-transaction returns the FSM to IDLE immediately. Strobes and ack drop asynchronously, and no ack is issued for the aborted request.
- **Register and null access:** request sampled at edge 0, `wbs_ack_o` high in cycle 1.
- **Core access:** request sampled at edge 0. `o_dbg_stb[k]` is high from cycle 1. If the core acks in cycle c, `wbs_ack_o` is high in cycle c+1. Minimum latency is 2 cycles.
- **Timeout:** with no core ack, `wbs_ack_o` rises in cycle TIMEOUT+2.

## Structure
- Package `subservient_dbg_pkg` holds:
  - the FSM state enum;
  - decode constants `SEL_HI=21`, `SEL_LO=20`, `SEL_REGS=2'd3`;
  - register offsets `REG_CTRL=0`, `REG_STATUS=1`;
  - `TIMEOUT_DATA=32'hDEAD_BEEF`.
- One sub-module, `subservient_dbg_regs`, owns CTRL/STATUS, the byte-masked writes, the W1C logic and the sticky-set input. The FSM, decode and counter live in the top.

## Test plan
- **Reset:** after `i_rst` deasserts, read `0x3030_0000` (CTRL) → ack in 1 cycle with data `0x0000_0707`. `o_core_rst`=3'b111 and `o_debug_mode`=3'b111.
- **Forwarded write:** write `0x3010_0040` = `0x1234_5678`, sel 4'hF.
  - `o_dbg_stb`=3'b010 and `o_dbg_adr`=`0x0000_0040`.
  - The core model acks after 3 cycles → `wbs_ack_o` rises exactly 1 cycle later, for exactly 1 cycle.
- **Forwarded read:** core 2 returns `0xCAFE_F00D` with an immediate ack → `wbs_dat_o`=`0xCAFE_F00D` on ack, 2 cycles after the request.
- **Timeout:** TIMEOUT=4, core 0 never acks → ack with `0xDEAD_BEEF` in cycle 6. STATUS reads `0x1`. Writing STATUS=`0x1` clears it to 0.
- **CTRL write:** write CTRL=`0x0000_0100` with sel 4'b0011 → `o_core_rst`=3'b000 and `o_debug_mode`=3'b001. Driving an ack on a non-selected core during FWD has no effect.
- **Reset mid-transaction:** pulse `i_rst` while in FWD → `o_dbg_stb` 0 immediately and no `wbs_ack_o`. A subsequent request completes normally.

Source files
------------

// File: rtl/subservient_dbg_pkg.sv
// Shared types and constants for the subservient debug Wishbone arbiter.
package subservient_dbg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Host address bits that pick the target (core index or register bank)
    localparam int          SEL_HI   = 21;
    localparam int          SEL_LO   = 20;
    localparam logic [1:0]  SEL_REGS = 2'd3;

    localparam logic [1:0]  REG_CTRL   = 2'd0;
    localparam logic [1:0]  REG_STATUS = 2'd1;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/subservient_dbg_regs.sv
// Control/status bank: per-core reset holds and debug_mode (CTRL),
// sticky per-core timeout flags with write-1-to-clear (STATUS).
module subservient_dbg_regs
    import subservient_dbg_pkg::*;
#(
    parameter int N_CORES = 3
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               wr_en,
    input  logic [1:0]         reg_adr,
    input  logic [31:0]        wdat,
    input  logic [3:0]         wsel,
    input  logic [N_CORES-1:0] set_timeout,
    output logic [31:0]        rdat,
    output logic [N_CORES-1:0] core_rst,
    output logic [N_CORES-1:0] debug_mode
);

    logic [N_CORES-1:0] ctrl_rst;
    logic [N_CORES-1:0] ctrl_dbg;
    logic [N_CORES-1:0] status;
    logic [N_CORES-1:0] status_clr;
    logic               unused_wr_bits;

    assign unused_wr_bits = ^{wdat, wsel};

    assign status_clr = (wr_en && reg_adr == REG_STATUS && wsel[0]) ? wdat[N_CORES-1:0] : '0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ctrl_rst <= '1;
            ctrl_dbg <= '1;
            status   <= '0;
        end else begin
            if (wr_en && reg_adr == REG_CTRL) begin
                if (wsel[0]) ctrl_rst <= wdat[N_CORES-1:0];
                if (wsel[1]) ctrl_dbg <= wdat[8 +: N_CORES];
            end
            // A new timeout is never lost to a concurrent clear
            status <= (status & ~status_clr) | set_timeout;
        end
    end

    always_comb begin
        rdat = '0;
        case (reg_adr)
            REG_CTRL: begin
                rdat[N_CORES-1:0]  = ctrl_rst;
                rdat[8 +: N_CORES] = ctrl_dbg;
            end
            REG_STATUS: rdat[N_CORES-1:0] = status;
            default: rdat = '0;
        endcase
    end

    assign core_rst   = ctrl_rst;
    assign debug_mode = ctrl_dbg;

endmodule

// File: rtl/subservient_dbg_mux.sv
// Wishbone debug arbiter: routes one host transaction at a time to a
// subservient core or the local register bank, with per-transaction timeout.
module subservient_dbg_mux
    import subservient_dbg_pkg::*;
#(
    parameter int N_CORES = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_we_i,
    input  logic [3:0]             wbs_sel_i,
    input  logic [31:0]            wbs_adr_i,
    input  logic [31:0]            wbs_dat_i,
    output logic                   wbs_ack_o,
    output logic [31:0]            wbs_dat_o,
    output logic [31:0]            o_dbg_adr,
    output logic [31:0]            o_dbg_dat,
    output logic [3:0]             o_dbg_sel,
    output logic                   o_dbg_we,
    output logic [N_CORES-1:0]     o_dbg_stb,
    input  logic [32*N_CORES-1:0]  i_dbg_rdt,
    input  logic [N_CORES-1:0]     i_dbg_ack,
    output logic [N_CORES-1:0]     o_core_rst,
    output logic [N_CORES-1:0]     o_debug_mode
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t              state, state_nxt;
    logic                req;
    logic [1:0]          sel;
    logic                is_core;
    logic                is_regs;
    logic [1:0]          cur;
    logic [7:0]          cnt;
    logic [31:0]         resp_dat;
    logic [N_CORES-1:0]  core_onehot;
    logic [N_CORES-1:0]  cur_onehot;
    logic                ack_hit;
    logic [31:0]         rdt_hit;
    logic                fwd_timeout;
    logic                reg_wr;
    logic [31:0]         reg_rdat;
    logic [N_CORES-1:0]  set_timeout;
    logic                unused_adr_bits;

    assign unused_adr_bits = ^wbs_adr_i[31:22];

    assign req     = wbs_cyc_i & wbs_stb_i;
    assign sel     = wbs_adr_i[SEL_HI:SEL_LO];
    assign is_regs = (sel == SEL_REGS);
    assign is_core = ({30'd0, sel} < 32'(N_CORES));

    always_comb begin
        core_onehot = '0;
        cur_onehot  = '0;
        ack_hit     = 1'b0;
        rdt_hit     = '0;
        for (int k = 0; k < N_CORES; k++) begin
            if (sel == 2'(k)) core_onehot[k] = 1'b1;
            if (cur == 2'(k)) begin
                cur_onehot[k] = 1'b1;
                ack_hit       = i_dbg_ack[k];
                rdt_hit       = i_dbg_rdt[32*k +: 32];
            end
        end
    end

    // Ack wins over a timeout expiring in the same cycle
    assign fwd_timeout = (state == ST_FWD) && !ack_hit && (cnt == 8'd0);
    assign set_timeout = fwd_timeout ? cur_onehot : '0;
    assign reg_wr      = (state == ST_IDLE) && req && is_regs && wbs_we_i;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req) state_nxt = is_core ? ST_FWD : ST_RESP;
            end
            ST_FWD: begin
                if (ack_hit || cnt == 8'd0) state_nxt = ST_RESP;
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_dbg_adr <= '0;
            o_dbg_dat <= '0;
            o_dbg_sel <= '0;
            o_dbg_we  <= 1'b0;
            o_dbg_stb <= '0;
            cur       <= '0;
            cnt       <= '0;
            resp_dat  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        if (is_core) begin
                            o_dbg_adr <= {12'h000, wbs_adr_i[19:0]};
                            o_dbg_dat <= wbs_dat_i;
                            o_dbg_sel <= wbs_sel_i;
                            o_dbg_we  <= wbs_we_i;
                            o_dbg_stb <= core_onehot;
                            cur       <= sel;
                            cnt       <= TIMEOUT_CNT;
                        end else begin
                            // Null-target accesses and all writes answer 0
                            resp_dat <= (is_regs && !wbs_we_i) ? reg_rdat : '0;
                        end
                    end
                end
                ST_FWD: begin
                    if (ack_hit) begin
                        resp_dat  <= rdt_hit;
                        o_dbg_stb <= '0;
                    end else if (cnt == 8'd0) begin
                        resp_dat  <= TIMEOUT_DATA;
                        o_dbg_stb <= '0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign wbs_ack_o = (state == ST_RESP);
    assign wbs_dat_o = wbs_ack_o ? resp_dat : '0;

    subservient_dbg_regs #(
        .N_CORES (N_CORES)
    ) u_regs (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .wr_en       (reg_wr),
        .reg_adr     (wbs_adr_i[3:2]),
        .wdat        (wbs_dat_i),
        .wsel        (wbs_sel_i),
        .set_timeout (set_timeout),
        .rdat        (reg_rdat),
        .core_rst    (o_core_rst),
        .debug_mode  (o_debug_mode)
    );

endmodule

// File: tb/tb_subservient_dbg_mux.sv
// Directed bench for subservient_dbg_mux: register bank, forwarding,
// timeout, stray acks and asynchronous reset mid-transaction.
module tb_subservient_dbg_mux;

    localparam int N_CORES = 3;
    localparam int TIMEOUT = 4;

    logic                  i_clk = 1'b0;
    logic                  i_rst;
    logic                  wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]            wbs_sel_i;
    logic [31:0]           wbs_adr_i, wbs_dat_i;
    logic                  wbs_ack_o;
    logic [31:0]           wbs_dat_o;
    logic [31:0]           o_dbg_adr, o_dbg_dat;
    logic [3:0]            o_dbg_sel;
    logic                  o_dbg_we;
    logic [N_CORES-1:0]    o_dbg_stb;
    logic [32*N_CORES-1:0] i_dbg_rdt;
    logic [N_CORES-1:0]    i_dbg_ack;
    logic [N_CORES-1:0]    o_core_rst, o_debug_mode;

    int n_cmp = 0;
    int n_err = 0;

    logic [N_CORES-1:0] stb1;
    logic [31:0]        adr1, dat1;
    logic               we1;

    always #5 i_clk = ~i_clk;

    subservient_dbg_mux #(
        .N_CORES (N_CORES),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .wbs_stb_i    (wbs_stb_i),
        .wbs_cyc_i    (wbs_cyc_i),
        .wbs_we_i     (wbs_we_i),
        .wbs_sel_i    (wbs_sel_i),
        .wbs_adr_i    (wbs_adr_i),
        .wbs_dat_i    (wbs_dat_i),
        .wbs_ack_o    (wbs_ack_o),
        .wbs_dat_o    (wbs_dat_o),
        .o_dbg_adr    (o_dbg_adr),
        .o_dbg_dat    (o_dbg_dat),
        .o_dbg_sel    (o_dbg_sel),
        .o_dbg_we     (o_dbg_we),
        .o_dbg_stb    (o_dbg_stb),
        .i_dbg_rdt    (i_dbg_rdt),
        .i_dbg_ack    (i_dbg_ack),
        .o_core_rst   (o_core_rst),
        .o_debug_mode (o_debug_mode)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Issue one host request; core model acks on `core` in cycle ack_cyc
    // (0 = never); noise >= 0 drives a stray ack from that core before then.
    task automatic access(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                          input logic we, input logic [3:0] sel, input int core,
                          input int ack_cyc, input logic [31:0] rdt, input int noise,
                          input int exp_lat, input logic [31:0] exp_dat);
        int          lat;
        logic [31:0] got;
        lat = 0;
        got = '0;
        wbs_adr_i = adr;
        wbs_dat_i = dat;
        wbs_we_i  = we;
        wbs_sel_i = sel;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (n == 1) begin
                stb1 = o_dbg_stb;
                adr1 = o_dbg_adr;
                dat1 = o_dbg_dat;
                we1  = o_dbg_we;
            end
            if (wbs_ack_o) begin
                lat = n;
                got = wbs_dat_o;
                break;
            end
            i_dbg_ack = '0;
            if (n == ack_cyc) begin
                i_dbg_ack[core]         = 1'b1;
                i_dbg_rdt[core*32 +: 32] = rdt;
            end else if (noise >= 0 && n < ack_cyc) begin
                i_dbg_ack[noise]          = 1'b1;
                i_dbg_rdt[noise*32 +: 32] = 32'hBAD0_BAD0;
            end
        end
        i_dbg_ack = '0;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_val({tag, "_dat"}, got, exp_dat);
        tick();
        check_val({tag, "_ack_pulse"}, 32'(wbs_ack_o), 32'd0);
    endtask

    initial begin
        i_rst     = 1'b1;
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_sel_i = '0;
        wbs_adr_i = '0;
        wbs_dat_i = '0;
        i_dbg_rdt = '0;
        i_dbg_ack = '0;
        tick();
        tick();
        i_rst = 1'b0;
        tick();

        check_val("rst_ack",      32'(wbs_ack_o),    32'd0);
        check_val("rst_dat",      wbs_dat_o,         32'd0);
        check_val("rst_stb",      32'(o_dbg_stb),    32'd0);
        check_val("rst_dbg_adr",  o_dbg_adr,         32'd0);
        check_val("rst_core_rst", 32'(o_core_rst),   32'h7);
        check_val("rst_dbg_mode", 32'(o_debug_mode), 32'h7);
        access("rd_ctrl_rst", 32'h3030_0000, 32'h0, 1'b0, 4'hF, 0, 0, 32'h0, -1, 1, 32'h0000_0707);

        // Forwarded write, core 1 acks in cycle 3 -> host ack in cycle 4
        access("fwd_wr", 32'h3010_0040, 32'h1234_5678, 1'b1, 4'hF, 1, 3, 32'h0, -1, 4, 32'h0);
        check_val("fwd_wr_stb", 32'(stb1), 32'h2);
        check_val("fwd_wr_adr", adr1,      32'h0000_0040);
        check_val("fwd_wr_dat", dat1,      32'h1234_5678);
        check_val("fwd_wr_we",  32'(we1),  32'd1);
        check_val("fwd_wr_stb_after", 32'(o_dbg_stb), 32'h0);

        // Forwarded read, core 2 acks immediately -> 2-cycle latency
        access("fwd_rd", 32'h3020_0008, 32'h0, 1'b0, 4'hF, 2, 1, 32'hCAFE_F00D, -1, 2, 32'hCAFE_F00D);
        check_val("fwd_rd_stb", 32'(stb1), 32'h4);
        check_val("fwd_rd_adr", adr1,      32'h0000_0008);
        check_val("fwd_rd_we",  32'(we1),  32'd0);

        // Timeout on core 0 with TIMEOUT=4 -> ack in cycle 6
        access("tmo", 32'h3000_0010, 32'h0, 1'b0, 4'hF, 0, 0, 32'h0, -1, 6, 32'hDEAD_BEEF);
        access("rd_status", 32'h3030_0004, 32'h0, 1'b0, 4'hF, 0, 0, 32'h0, -1, 1, 32'h1);
        access("clr_status", 32'h3030_0004, 32'h1, 1'b1, 4'hF, 0, 0, 32'h0, -1, 1, 32'h0);
        access("rd_status2", 32'h3030_0004, 32'h0, 1'b0, 4'hF, 0, 0, 32'h0, -1, 1, 32'h0);

        // CTRL write with byte enables 0011
        access("wr_ctrl", 32'h3030_0000, 32'h0000_0100, 1'b1, 4'b0011, 0, 0, 32'h0, -1, 1, 32'h0);
        check_val("ctrl_core_rst", 32'(o_core_rst),   32'h0);
        check_val("ctrl_dbg_mode", 32'(o_debug_mode), 32'h1);
        access("rd_ctrl", 32'h3030_0000, 32'h0, 1'b0, 4'hF, 0, 0, 32'h0, -1, 1, 32'h0000_0100);
        // Only byte 1 enabled: reset holds stay 0, debug_mode becomes 111
        access("wr_ctrl_b1", 32'h3030_0000, 32'h0000_0707, 1'b1, 4'b0010, 0, 0, 32'h0, -1, 1, 32'h0);
        check_val("b1_core_rst", 32'(o_core_rst),   32'h0);
        check_val("b1_dbg_mode", 32'(o_debug_mode), 32'h7);
        access("wr_reg2", 32'h3030_0008, 32'hFFFF_FFFF, 1'b1, 4'hF, 0, 0, 32'h0, -1, 1, 32'h0);
        access("rd_reg2", 32'h3030_0008, 32'h0, 1'b0, 4'hF, 0, 0, 32'h0, -1, 1, 32'h0);
        access("rd_ctrl2", 32'h3030_0000, 32'h0, 1'b0, 4'hF, 0, 0, 32'h0, -1, 1, 32'h0000_0700);

        // Stray ack from core 2 while core 0 is being served
        access("noise", 32'h3000_0020, 32'h0, 1'b0, 4'hF, 0, 3, 32'h0000_1111, 2, 4, 32'h0000_1111);
        access("rd_status3", 32'h3030_0004, 32'h0, 1'b0, 4'hF, 0, 0, 32'h0, -1, 1, 32'h0);

        // Reset mid-transaction
        wbs_adr_i = 32'h3010_0000;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'hF;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        tick();
        tick();
        check_val("mid_stb_before", 32'(o_dbg_stb), 32'h2);
        i_rst = 1'b1;
        #1;
        check_val("mid_stb_async", 32'(o_dbg_stb), 32'h0);
        check_val("mid_ack_async", 32'(wbs_ack_o), 32'd0);
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        i_dbg_ack = 3'b010;
        tick();
        i_rst     = 1'b0;
        i_dbg_ack = '0;
        for (int n = 0; n < 3; n++) begin
            tick();
            check_val("mid_no_ack", 32'(wbs_ack_o), 32'd0);
        end
        check_val("mid_core_rst", 32'(o_core_rst), 32'h7);
        access("after_rst", 32'h3010_0004, 32'h0, 1'b0, 4'hF, 1, 2, 32'h5A5A_A5A5, -1, 3, 32'h5A5A_A5A5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
